// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides. Most opcodes finish in one
// cycle. MUL uses iterative shift-add and DIV uses iterative restoring division, each over WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [3:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Yout,
  output logic                 err
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XNOR = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_EQ   = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [2*WIDTH-1:0]    yout_r;
  logic                  err_r;
  logic                  is_div_r;
  logic [SW-1:0]         cnt_r;
  logic [WIDTH-1:0]      b_r;
  logic [2*WIDTH-1:0]    acc_r;
  logic [2*WIDTH-1:0]    mcand_r;
  logic [WIDTH-1:0]      quo_r;
  logic [WIDTH-1:0]      rem_r;

  logic [2*WIDTH-1:0]    alu_s;
  logic [2*WIDTH-1:0]    mul_acc_next_s;
  logic [WIDTH:0]        div_trial_s;
  logic                  div_ge_s;
  logic [WIDTH-1:0]      div_rem_next_s;
  logic [WIDTH-1:0]      div_quo_next_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Yout      = yout_r;
  assign err       = err_r;

  // Single-cycle result; the DIV entry is only used for the divide-by-zero case
  always_comb begin
    alu_s = {(2*WIDTH){1'b0}};
    case (sel)
      OP_ADD:  alu_s = {{(WIDTH-1){1'b0}}, {1'b0, A} + {1'b0, B}};
      OP_SUB:  alu_s = {{(WIDTH-1){1'b0}}, {1'b0, A} - {1'b0, B}};
      OP_MUL:  alu_s = {(2*WIDTH){1'b0}};
      OP_DIV:  alu_s = {A, {WIDTH{1'b1}}};
      OP_AND:  alu_s = {{WIDTH{1'b0}}, A & B};
      OP_OR:   alu_s = {{WIDTH{1'b0}}, A | B};
      OP_XOR:  alu_s = {{WIDTH{1'b0}}, A ^ B};
      OP_NOT:  alu_s = {{WIDTH{1'b0}}, ~A};
      OP_NAND: alu_s = {{WIDTH{1'b0}}, ~(A & B)};
      OP_NOR:  alu_s = {{WIDTH{1'b0}}, ~(A | B)};
      OP_XNOR: alu_s = {{WIDTH{1'b0}}, ~(A ^ B)};
      OP_SHL:  alu_s = {{WIDTH{1'b0}}, A} << B[SW-1:0];
      OP_SHR:  alu_s = {{WIDTH{1'b0}}, A >> B[SW-1:0]};
      OP_EQ:   alu_s = {{(2*WIDTH-1){1'b0}}, (A == B)};
      OP_GT:   alu_s = {{(2*WIDTH-1){1'b0}}, (A > B)};
      OP_PASS: alu_s = {{WIDTH{1'b0}}, A};
      default: alu_s = {(2*WIDTH){1'b0}};
    endcase
  end

  // One iteration step of shift-add multiply and restoring divide
  always_comb begin
    mul_acc_next_s = acc_r;
    div_rem_next_s = rem_r;
    div_trial_s    = {rem_r, quo_r[WIDTH-1]};
    div_ge_s       = (div_trial_s >= {1'b0, b_r});
    if (quo_r[0]) begin
      mul_acc_next_s = acc_r + mcand_r;
    end else begin
      mul_acc_next_s = acc_r;
    end
    // The remainder after subtraction is always below B, so modulo-2^WIDTH subtraction is exact
    if (div_ge_s) begin
      div_rem_next_s = div_trial_s[WIDTH-1:0] - b_r;
    end else begin
      div_rem_next_s = div_trial_s[WIDTH-1:0];
    end
    div_quo_next_s = {quo_r[WIDTH-2:0], div_ge_s};
  end

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      yout_r      <= {(2*WIDTH){1'b0}};
      err_r       <= 1'b0;
      is_div_r    <= 1'b0;
      cnt_r       <= {SW{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      mcand_r     <= {(2*WIDTH){1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            in_ready_r <= 1'b0;
            cnt_r      <= {SW{1'b0}};
            if (sel == OP_MUL) begin
              is_div_r <= 1'b0;
              acc_r    <= {(2*WIDTH){1'b0}};
              mcand_r  <= {{WIDTH{1'b0}}, A};
              quo_r    <= B;
              state_r  <= BUSY;
            end else if ((sel == OP_DIV) && (B != {WIDTH{1'b0}})) begin
              is_div_r <= 1'b1;
              rem_r    <= {WIDTH{1'b0}};
              quo_r    <= A;
              b_r      <= B;
              state_r  <= BUSY;
            end else begin
              yout_r      <= alu_s;
              err_r       <= (sel == OP_DIV);
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r + {{(SW-1){1'b0}}, 1'b1};
          if (is_div_r) begin
            rem_r <= div_rem_next_s;
            quo_r <= div_quo_next_s;
          end else begin
            acc_r   <= mul_acc_next_s;
            mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
            quo_r   <= {1'b0, quo_r[WIDTH-1:1]};
          end
          if (cnt_r == LAST_STEP) begin
            if (is_div_r) begin
              yout_r <= {div_rem_next_s, div_quo_next_s};
            end else begin
              yout_r <= mul_acc_next_s;
            end
            err_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand width; legal values are powers of two from 4 to 64.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  the operation on A/B/sel is offered.
REQ-005 in_ready  output  1  the block can accept an operation.
REQ-006 A  input  WIDTH  operand A, unsigned.
REQ-007 B  input  WIDTH  operand B, unsigned.
REQ-008 sel  input  4  opcode.
REQ-009 out_valid  output  1  Yout and err hold a result.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 Yout  output  2*WIDTH  registered result.
REQ-012 err  output  1  the result is from a divide by zero.

Function
REQ-013 The block SHALL have three states: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 An operation SHALL be accepted on a cycle with in_valid=1 and in_ready=1; A, B and sel are captured at that cycle.
REQ-016 Operand changes after acceptance SHALL NOT affect the result.
REQ-017 Opcodes, with results zero-extended to 2*WIDTH unless stated:
- 0000 ADD: {carry, A+B}.
- 0001 SUB: {borrow, A-B mod 2^WIDTH}.
- 0010 MUL: full 2*WIDTH product.
- 0011 DIV: {remainder, quotient}, with the quotient in the low WIDTH bits.
- 0100 AND; 0101 OR; 0110 XOR.
- 0111 NOT A; 1000 NAND; 1001 NOR; 1010 XNOR.
- 1011 SHL: A << B[log2(WIDTH)-1:0], shown in 2*WIDTH bits.
- 1100 SHR: logical A >> B[log2(WIDTH)-1:0].
- 1101 EQ: 1 when A==B.
- 1110 GT: 1 when A>B.
- 1111 PASS: A.
REQ-018 Single-cycle opcodes (all except MUL and DIV, and DIV with B==0) SHALL go IDLE->DONE on acceptance, so out_valid=1 at accept cycle N+1.
REQ-019 MUL SHALL go IDLE->BUSY and use iterative shift-add, one bit per cycle over WIDTH cycles, then go BUSY->DONE; out_valid=1 at N+WIDTH+1.
REQ-020 DIV with B!=0 SHALL use iterative restoring division, one quotient bit per cycle, with the same latency as MUL.
REQ-021 DIV with B==0 SHALL go directly to DONE at N+1 with quotient all ones, remainder=A and err=1.
REQ-022 err SHALL be 0 for every other result.
REQ-023 In DONE, Yout, err and out_valid SHALL hold stable until out_ready=1.
REQ-024 DONE with out_ready=1 SHALL return to IDLE on the next edge; in_ready=1 the cycle after the handshake, with no new acceptance in the handshake cycle.
REQ-025 in_valid during BUSY or DONE SHALL be ignored and SHALL NOT queue an operation.
REQ-026 Yout SHALL hold its last value in IDLE; consumers SHALL qualify it with out_valid.
REQ-027 out_ready=1 outside DONE SHALL have no effect.

Reset
REQ-028 On a clock edge with rst=1, the state SHALL become IDLE, Yout=0, err=0 and out_valid=0, with in_ready=1 from the next cycle.
REQ-029 rst SHALL take priority over every event in the same cycle, including acceptance and the output handshake.
REQ-030 rst during BUSY SHALL abort the iterative operation and discard it with no partial result shown.
REQ-031 Outputs SHALL be deterministic from the first cycle after reset.

Verification (WIDTH=32)
REQ-032 ADD, A=0x10, B=0x08, accepted at cycle N -> out_valid=1 at N+1, Yout=0x18, err=0.
REQ-033 MUL, A=B=0xFFFFFFFF -> out_valid=1 at N+33, Yout=0xFFFFFFFE_00000001; a new in_valid at N+5 is ignored.
REQ-034 DIV, A=100, B=7 -> out_valid=1 at N+33, Yout[31:0]=14, Yout[63:32]=2, err=0.
REQ-035 DIV, A=0x55, B=0 -> at N+1 Yout[31:0]=0xFFFFFFFF, Yout[63:32]=0x55, err=1.
REQ-036 SUB, A=0x08, B=0x10, with out_ready held 0 for 10 cycles -> Yout=0x1_FFFFFFF8 stable throughout; IDLE the cycle after out_ready=1.
REQ-037 rst=1 at N+10 of a MUL -> out_valid stays 0; in_ready=1 at N+11; the next ADD completes normally.
